// File: rtl/seq_shift_add_mult.sv
// Iterative shift-and-add multiplier, BITS_PER_CYCLE multiplier bits retired per clock, valid/ready on both sides.
// Define SHIFT_ADD_SIGNED_EN to add the run-time is_signed port (sign-magnitude iteration, negate at completion).
module seq_shift_add_mult #(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SHIFT_ADD_SIGNED_EN
    input  logic                 is_signed,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam int N   = WIDTH / BITS_PER_CYCLE;
    localparam int K_W = (N > 1) ? $clog2(N) : 1;
    localparam int PW  = 2 * WIDTH;

    generate
        if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
            $error("seq_shift_add_mult: WIDTH must be in 2..64");
        end
        if (BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > WIDTH) begin : g_bad_bpc
            $error("seq_shift_add_mult: BITS_PER_CYCLE must be in 1..WIDTH");
        end else if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_div
            $error("seq_shift_add_mult: WIDTH must be a multiple of BITS_PER_CYCLE");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [PW-1:0]    acc;
    logic [K_W-1:0]   k;
    logic             neg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             neg_in;
    logic [PW-1:0]    pp;
    logic [PW-1:0]    acc_next;
    logic [PW-1:0]    prod_final;
    logic             last_iter;
    int               shamt;

    // Operand conditioning at the accepting edge: magnitudes plus the product sign.
    always_comb begin
        a_mag  = a;
        b_mag  = b;
        neg_in = 1'b0;
`ifdef SHIFT_ADD_SIGNED_EN
        if (is_signed) begin
            if (a[WIDTH-1]) a_mag = -a;
            if (b[WIDTH-1]) b_mag = -b;
            neg_in = a[WIDTH-1] ^ b[WIDTH-1];
        end
`endif
    end

    // NOTE: blocking '=' is right here because pp is rebuilt term by term within one evaluation; registers below use '<=' only.
    always_comb begin
        pp = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (b_reg[j]) pp = pp + (PW'(a_reg) << j);
        end
        shamt      = int'(k) * BITS_PER_CYCLE;
        acc_next   = acc + (pp << shamt);
        prod_final = neg ? -acc_next : acc_next;
    end

    assign last_iter = (k == K_W'(N - 1));
    assign in_ready  = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every variable gets its default first so no branch can infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = BUSY;
            BUSY:    if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            k         <= '0;
            neg       <= 1'b0;
            result    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a_mag;
                        b_reg <= b_mag;
                        neg   <= neg_in;
                        acc   <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    b_reg <= b_reg >> BITS_PER_CYCLE;
                    k     <= k + K_W'(1);
                    if (last_iter) begin
                        result    <= prod_final;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // result deliberately keeps its value after the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
